fetch_unit: RTL

Parametrised instruction-fetch front end for the next-generation core. It replaces the fixed single-cycle I-mem read (pc -> instr in the same cycle) with a request/grant/response memory handshake and a DEPTH-entry prefetch queue. It handles branch/jump redirect flushes, discards stale in-flight responses, and supports a halt drain. It sits between the PC/branch logic and the instruction memory, and feeds decode through a valid/ready interface.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, default widths and the counter-width helper for the fetch front end.
package fetch_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;
   localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [DATA_W_DEF-1:0] instr;
   } fetch_entry_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry queue of fetch entries with flush; DEPTH need not be a power of two.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  entry_t                   data_i,
   output entry_t                   data_o,
   output logic [cnt_w(DEPTH)-1:0]  count_o,
   output logic                     empty_o,
   output logic                     full_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            do_push, do_pop;

   always_comb begin
      empty_o = cnt_q == '0;
      full_o  = cnt_q == CW'(DEPTH);
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      rd_d    = flush_i ? '0 : do_pop ? (rd_q == LAST ? '0 : rd_q + PW'(1)) : rd_q;
      wr_d    = flush_i ? '0 : do_push ? (wr_q == LAST ? '0 : wr_q + PW'(1)) : wr_q;
      cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
      count_o = cnt_q;
      data_o  = mem_q[rd_q];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: request/grant instruction fetch with a DEPTH-entry prefetch queue, redirect flush and halt drain.
// Define FETCH_BYPASS_EN to hand a response straight to decode when the queue is empty.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               DATA_W   = DATA_W_DEF,
   parameter int               ADDR_W   = ADDR_W_DEF,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_pc,
   input  logic              hlt,
   output logic              halted
);
   localparam int CW = cnt_w(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]     out_q, out_d, drop_q, drop_d, count;
   logic              empty, full, xfer, rv, acc, push, q_pop;
   entry_t            head, wr_entry;
`ifdef FETCH_BYPASS_EN
   logic              byp;
`endif

   always_comb begin
      imem_req  = rst_n && !redir_valid && !hlt && !full &&
                  ({1'b0, count} + {1'b0, out_q} < (CW+1)'(DEPTH));
      imem_addr = fetch_pc_q;
      xfer      = imem_req && imem_gnt;
      // responses with nothing outstanding belong to work abandoned by reset
      rv        = imem_rvalid && out_q != '0;
      acc       = rv && drop_q == '0;
      wr_entry.pc    = resp_pc_q;
      wr_entry.instr = imem_rdata;
`ifdef FETCH_BYPASS_EN
      byp         = acc && empty && !redir_valid;
      instr_valid = !empty || byp;
      instr       = empty ? imem_rdata : head.instr;
      instr_pc    = empty ? resp_pc_q : head.pc;
      push        = acc && !(byp && instr_ready);
      q_pop       = !empty && instr_ready;
`else
      instr_valid = !empty;
      instr       = head.instr;
      instr_pc    = head.pc;
      push        = acc;
      q_pop       = instr_valid && instr_ready;
`endif
      out_d      = out_q + CW'(xfer) - CW'(rv);
      // on redirect every response still in flight after this cycle is stale
      drop_d     = redir_valid ? out_q - CW'(rv) : drop_q - CW'(rv && drop_q != '0);
      fetch_pc_d = redir_valid ? redir_pc : fetch_pc_q + ADDR_W'(xfer);
      resp_pc_d  = redir_valid ? redir_pc : resp_pc_q + ADDR_W'(acc);
      halted     = hlt && out_q == '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (q_pop),
      .flush_i (redir_valid),
      .data_i  (wr_entry),
      .data_o  (head),
      .count_o (count),
      .empty_o (empty),
      .full_o  (full)
   );
endmodule
